// File: rtl/cmac_accum_pkg.sv
// Shared types, widths and arithmetic helpers
// for the CMAC accumulation stage.
package cmac_accum_pkg;

  localparam int PROD_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  function automatic int tree_w(input int n);
    return PROD_W + $clog2(n);
  endfunction

  // Result is clamped to a signed w-bit range;
  // the caller keeps the low w bits.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 w,
    output logic               clamp
  );
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    s     = a + b;
    mx    = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn    = -(64'sd1 <<< (w - 1));
    clamp = 1'b0;
    if (s > mx) begin
      s     = mx;
      clamp = 1'b1;
    end else if (s < mn) begin
      s     = mn;
      clamp = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/cmac_add_tree.sv
// Combinational masked adder tree:
// NUM_PROD signed products to one exact sum.
module cmac_add_tree
  import cmac_accum_pkg::*;
#(
  parameter int NUM_PROD = 8
) (
  input  logic [NUM_PROD*PROD_W-1:0]          in_data,
  input  logic [NUM_PROD-1:0]                 in_mask,
  output logic signed [tree_w(NUM_PROD)-1:0]  sum
);

  localparam int TW = tree_w(NUM_PROD);

  logic signed [PROD_W-1:0] p;

  always_comb begin
    sum = '0;
    p   = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      p = in_data[i*PROD_W +: PROD_W];
      if (in_mask[i]) begin
        sum = sum + TW'(p);
      end
    end
  end

endmodule

// File: rtl/cmac_accum_unit.sv
// Registered product reduction followed by a
// framed, saturating group accumulator.
module cmac_accum_unit
  import cmac_accum_pkg::*;
#(
  parameter int NUM_PROD = 8,
  parameter int ACC_W    = 22
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        in_pvld,
  input  logic [NUM_PROD*PROD_W-1:0]  in_data,
  input  logic [NUM_PROD-1:0]         in_mask,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        out_pvld,
  output logic signed [ACC_W-1:0]     out_data,
  output logic                        out_sat,
  output logic                        err_pulse
);

  localparam int TW = tree_w(NUM_PROD);

  logic signed [TW-1:0] tree_sum;

  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_first_q, s1_first_d;
  logic                 s1_last_q, s1_last_d;
  logic signed [TW-1:0] s1_sum_q, s1_sum_d;

  acc_state_e             state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic                    out_pvld_q, out_pvld_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    err_q, err_d;

  logic signed [ACC_W-1:0] sum_ext;
  logic                    beat_start;
  logic                    beat_orphan;
  logic                    beat_acc;

  cmac_add_tree #(
    .NUM_PROD (NUM_PROD)
  ) u_tree (
    .in_data (in_data),
    .in_mask (in_mask),
    .sum     (tree_sum)
  );

  always_comb begin
    s1_vld_d   = in_pvld;
    s1_first_d = in_pvld & in_first;
    s1_last_d  = in_pvld & in_last;
    s1_sum_d   = in_pvld ? tree_sum : s1_sum_q;
  end

  assign sum_ext     = ACC_W'(s1_sum_q);
  assign beat_start  = s1_vld_q & s1_first_q;
  assign beat_orphan = s1_vld_q & ~s1_first_q
                     & (state_q == IDLE);
  assign beat_acc    = s1_vld_q & ~s1_first_q
                     & (state_q == ACCUM);

  always_comb begin
    logic clamp;
    clamp      = 1'b0;
    state_d    = state_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    out_pvld_d = 1'b0;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    err_d      = 1'b0;
    unique case (1'b1)
      beat_start: begin
        // A first while in ACCUM drops the partial group.
        err_d = (state_q == ACCUM);
        acc_d = sum_ext;
        sat_d = 1'b0;
        if (s1_last_q) begin
          state_d    = IDLE;
          out_pvld_d = 1'b1;
          out_data_d = sum_ext;
          out_sat_d  = 1'b0;
        end else begin
          state_d = ACCUM;
        end
      end
      beat_orphan: begin
        err_d = 1'b1;
      end
      beat_acc: begin
        acc_d = ACC_W'(sat_add(64'(acc_q), 64'(sum_ext),
                               ACC_W, clamp));
        sat_d = sat_q | clamp;
        if (s1_last_q) begin
          state_d    = IDLE;
          out_pvld_d = 1'b1;
          out_data_d = acc_d;
          out_sat_d  = sat_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      state_q    <= IDLE;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      out_pvld_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_sum_q   <= s1_sum_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      out_pvld_q <= out_pvld_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      err_q      <= err_d;
    end
  end

  assign out_pvld  = out_pvld_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_cmac_accum_unit.sv
// Directed bench for cmac_accum_unit with
// hand-computed group results.
module tb_cmac_accum_unit;

  localparam int NP = 8;
  localparam int AW = 22;

  logic                 clk;
  logic                 rstn;
  logic                 in_pvld;
  logic [NP*16-1:0]     in_data;
  logic [NP-1:0]        in_mask;
  logic                 in_first;
  logic                 in_last;
  logic                 out_pvld;
  logic signed [AW-1:0] out_data;
  logic                 out_sat;
  logic                 err_pulse;

  int errors = 0;
  int checks = 0;

  cmac_accum_unit #(
    .NUM_PROD (NP),
    .ACC_W    (AW)
  ) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_pvld         (in_pvld),
    .in_data         (in_data),
    .in_mask         (in_mask),
    .in_first        (in_first),
    .in_last         (in_last),
    .out_pvld        (out_pvld),
    .out_data        (out_data),
    .out_sat         (out_sat),
    .err_pulse       (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NP*16-1:0] rep(input logic signed [15:0] v);
    logic [NP*16-1:0] d;
    for (int i = 0; i < NP; i++) d[i*16 +: 16] = v;
    return d;
  endfunction

  function automatic logic [NP*16-1:0] lanes4(
    input logic signed [15:0] a, input logic signed [15:0] b,
    input logic signed [15:0] c, input logic signed [15:0] e);
    logic [NP*16-1:0] d;
    for (int i = 0; i < NP; i++) d[i*16 +: 16] = 16'h7FFF;
    d[15:0]  = a;
    d[31:16] = b;
    d[47:32] = c;
    d[63:48] = e;
    return d;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic beat(input logic f, input logic l,
                      input logic [NP*16-1:0] d,
                      input logic [NP-1:0] m);
    in_pvld  = 1'b1;
    in_first = f;
    in_last  = l;
    in_data  = d;
    in_mask  = m;
    @(negedge clk);
  endtask

  task automatic gap();
    in_pvld  = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    in_pvld = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = '0; in_mask = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_pvld !== 1'b0 || out_data !== '0 || out_sat !== 1'b0
        || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: pvld=%b data=%0d sat=%b err=%b expected all 0",
               out_pvld, out_data, out_sat, err_pulse);
    end
    rstn = 1'b1;
    gap();
    gap();
    checks++;
    if (out_pvld !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: pvld=%b err=%b expected 0 0",
               out_pvld, err_pulse);
    end
  endtask

  task automatic test_single();
    beat(1'b1, 1'b1, rep(16'sd3), 8'hFF);
    gap();
    checks++;
    if (out_pvld !== 1'b1 || out_data !== 22'sd24 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL single: pvld=%b data=%0d sat=%b expected 1 24 0",
               out_pvld, out_data, out_sat);
    end
    gap();
    checks++;
    if (out_pvld !== 1'b0 || out_data !== 22'sd24) begin
      errors++;
      $display("FAIL single_hold: pvld=%b data=%0d expected 0 24",
               out_pvld, out_data);
    end
  endtask

  task automatic test_three_beat();
    beat(1'b1, 1'b0, lanes4(16'sd25, 16'sd25, 16'sd25, 16'sd25), 8'h0F);
    gap();
    checks++;
    if (out_pvld !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL three_gap: pvld=%b err=%b expected 0 0",
               out_pvld, err_pulse);
    end
    gap();
    beat(1'b0, 1'b0, lanes4(-16'sd62, -16'sd62, -16'sd63, -16'sd63), 8'h0F);
    gap();
    beat(1'b0, 1'b1, lanes4(16'sd1, 16'sd2, 16'sd3, 16'sd1), 8'h0F);
    gap();
    checks++;
    if (out_pvld !== 1'b1 || out_data !== -22'sd143 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL three_beat: pvld=%b data=%0d sat=%b expected 1 -143 0",
               out_pvld, out_data, out_sat);
    end
  endtask

  task automatic test_back_to_back();
    beat(1'b1, 1'b0, rep(16'sd1), 8'hFF);
    beat(1'b0, 1'b1, rep(16'sd2), 8'hFF);
    beat(1'b1, 1'b1, rep(-16'sd1), 8'hFF);
    checks++;
    if (out_pvld !== 1'b1 || out_data !== 22'sd24) begin
      errors++;
      $display("FAIL b2b_first: pvld=%b data=%0d expected 1 24",
               out_pvld, out_data);
    end
    gap();
    checks++;
    if (out_pvld !== 1'b1 || out_data !== -22'sd8) begin
      errors++;
      $display("FAIL b2b_second: pvld=%b data=%0d expected 1 -8",
               out_pvld, out_data);
    end
    gap();
    checks++;
    if (out_pvld !== 1'b0 || out_data !== -22'sd8) begin
      errors++;
      $display("FAIL b2b_hold: pvld=%b data=%0d expected 0 -8",
               out_pvld, out_data);
    end
  endtask

  task automatic test_orphan();
    beat(1'b0, 1'b1, rep(16'sd5), 8'hFF);
    gap();
    checks++;
    if (err_pulse !== 1'b1 || out_pvld !== 1'b0) begin
      errors++;
      $display("FAIL orphan: err=%b pvld=%b expected 1 0",
               err_pulse, out_pvld);
    end
    gap();
    checks++;
    if (err_pulse !== 1'b0 || out_pvld !== 1'b0 || out_data !== -22'sd8) begin
      errors++;
      $display("FAIL orphan_after: err=%b pvld=%b data=%0d expected 0 0 -8",
               err_pulse, out_pvld, out_data);
    end
  endtask

  task automatic test_restart();
    beat(1'b1, 1'b0, lanes4(16'sd25, 16'sd25, 16'sd25, 16'sd25), 8'h0F);
    beat(1'b1, 1'b0, rep(16'sd3), 8'hFF);
    beat(1'b0, 1'b1, rep(16'sd3), 8'hFF);
    checks++;
    if (err_pulse !== 1'b1 || out_pvld !== 1'b0) begin
      errors++;
      $display("FAIL restart_err: err=%b pvld=%b expected 1 0",
               err_pulse, out_pvld);
    end
    gap();
    checks++;
    if (out_pvld !== 1'b1 || out_data !== 22'sd48 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL restart_result: pvld=%b data=%0d err=%b expected 1 48 0",
               out_pvld, out_data, err_pulse);
    end
  endtask

  task automatic test_saturation(input logic signed [15:0] v,
                                 input logic signed [AW-1:0] exp_d,
                                 input logic exp_s);
    beat(1'b1, 1'b0, rep(v), 8'hFF);
    for (int i = 0; i < 14; i++) beat(1'b0, 1'b0, rep(v), 8'hFF);
    beat(1'b0, 1'b1, rep(v), 8'hFF);
    gap();
    checks++;
    if (out_pvld !== 1'b1 || out_data !== exp_d || out_sat !== exp_s) begin
      errors++;
      $display("FAIL saturation(%0d): pvld=%b data=%0d sat=%b expected 1 %0d %b",
               v, out_pvld, out_data, out_sat, exp_d, exp_s);
    end
  endtask

  task automatic test_async_reset();
    beat(1'b1, 1'b1, rep(16'sd3), 8'hFF);
    gap();
    beat(1'b1, 1'b0, rep(16'sd4), 8'hFF);
    beat(1'b0, 1'b1, rep(16'sd4), 8'hFF);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_pvld !== 1'b0 || out_data !== '0 || out_sat !== 1'b0
        || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pvld=%b data=%0d sat=%b err=%b expected all 0",
               out_pvld, out_data, out_sat, err_pulse);
    end
    in_pvld = 1'b0; in_first = 1'b0; in_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    gap();
    gap();
    checks++;
    if (out_pvld !== 1'b0 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: pvld=%b err=%b expected 0 0",
               out_pvld, err_pulse);
    end
    beat(1'b1, 1'b0, rep(16'sd2), 8'hFF);
    beat(1'b0, 1'b1, rep(16'sd5), 8'hF0);
    gap();
    checks++;
    if (out_pvld !== 1'b1 || out_data !== 22'sd36 || err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_group: pvld=%b data=%0d err=%b expected 1 36 0",
               out_pvld, out_data, err_pulse);
    end
  endtask

  initial begin
    rstn = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_three_beat();
    test_back_to_back();
    test_orphan();
    test_restart();
    test_saturation(16'sd16384, 22'sd2097151, 1'b1);
    test_saturation(-16'sd16384, -22'sd2097152, 1'b0);
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmac_accum_unit.md
# cmac_accum_unit

Downstream accumulation stage for the approximate int8 MAC cell. It consumes NUM_PROD signed 16-bit products per cycle from the multiplier array and reduces them through a registered adder tree. It then accumulates the per-beat sums across a framed channel group, from a first beat to a last beat, and emits one saturated signed result per group toward the CACC side.

## Interface
- NUM_PROD, 8: products per beat; power of two, 2..16.
- ACC_W, 22: accumulator/result width, signed; ACC_W ≥ 16+log2(NUM_PROD)+1.
- nvdla_core_clk  in  1  single clock; all state on rising edge.
- nvdla_core_rstn  in  1  asynchronous, active-low reset.
- in_pvld  in  1  beat valid; no backpressure.
- in_data  in  NUM_PROD*16  packed signed products; product i at [16i+15:16i].
- in_mask  in  NUM_PROD  1 = product i participates; 0 = treated as zero.
- in_first  in  1  first beat of a group; qualified by in_pvld.
- in_last  in  1  last beat of a group; qualified by in_pvld.
- out_pvld  out  1  one-cycle pulse, result valid.
- out_data  out  ACC_W  signed group result.
- out_sat  out  1  group saturated at least once; valid with out_pvld.
- err_pulse  out  1  one-cycle framing-error pulse.

## Operation
- Stage 1: masked products are sign-extended to 16+log2(NUM_PROD) bits and summed exactly with no overflow. The sum is registered together with the vld, first and last bits.
- Stage 2 FSM, two states:
  - IDLE → ACCUM on a stage-1 beat with first=1 and last=0. Action: acc = sext(sum) and sat = 0.
  - ACCUM stays in ACCUM on a beat with first=0 and last=0. Action: acc = satadd(acc, sum).
  - ACCUM → IDLE on a beat with last=1. The final value is computed as above and then registered to the output.
- first=1 and last=1 on the same beat: single-beat group. The result is sext(sum) with sat=0, and the state ends in IDLE.
- first=1 while in ACCUM: the partial group is discarded, err_pulse fires, and a new group starts with this beat. If last is also 1, the result is emitted.
- Beat with first=0 while in IDLE: the beat is ignored, err_pulse fires, and no output is produced. A last=1 on such a beat is ignored too.
- satadd: full-precision signed add, clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets the sticky sat flag for the group. Saturation is non-recoverable: later beats add to the clamped value.
- Cycles without a valid beat leave acc and the state unchanged. Gaps inside a group are legal.
- out_data holds the last result until the next out_pvld. It is not cleared at group start.

## Timing
- Latency: a beat with in_last on cycle t gives out_pvld on cycle t+2 (the stage-1 register plus the output register).
- Throughput: one beat per cycle, with back-to-back groups. A last on t and a first on t+1 gives results on t+2 and t+3 respectively.
- err_pulse is asserted at t+2 relative to the offending input beat.
- Reset values: out_pvld=0, out_data=0, out_sat=0, err_pulse=0, state=IDLE, acc=0, and all stage-1 registers=0.
- Reset mid-group: the partial group is lost silently. No output or err pulse follows the release of reset.

## Structure
- Package cmac_accum_pkg holds:
  - the product width constant (16);
  - the tree width function (16+clog2(NUM_PROD));
  - the state enum {IDLE, ACCUM};
  - a saturating-add function parameterized on ACC_W.
- Sub-module cmac_add_tree is the combinational masked adder tree (NUM_PROD × 16 → tree width). The stage-1 register stays in the top level.

## Test plan
- Single-beat group: in_data all products = 3, mask all ones, first=last=1 → 2 cycles later out_pvld=1, out_data=24, out_sat=0.
- Three-beat group: beat sums 100, -250 and 7 (mask=8'h0F, with masked lanes carrying 0x7FFF) → out_data=-143 at t+2 of the last beat. The gap cycles inside the group must have no effect.
- Saturation: 16 beats, every product 16384 → the 16th beat reaches 2097152, so out_data=2097151 and out_sat=1. The same test with -16384 gives -2097152 with out_sat=0, because that value is exactly representable.
- Framing errors:
  - An orphan beat in IDLE → err_pulse and no out_pvld.
  - first during ACCUM → err_pulse, and the new group result excludes the old partial sum.
- Back-to-back groups: last on t, then a single-beat group on t+1 → out_pvld on t+2 and on t+3 with the correct distinct values.
- Async reset: assert nvdla_core_rstn low mid-group, between clock edges → all outputs are 0 immediately. Reset released, then a fresh group → correct result, with no spurious err_pulse.
